// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 4-digit common-anode 7-segment scan scheduler
// Round-robin digit slots with dead-time blanking, per-frame snapshot, lz suppression and blink.
module seg_scan_ctrl #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic       lz_en,
  input  logic [3:0] blink_mask,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [3:0]    s0, s1, s2, s3;
  logic [BW-1:0] bcnt;
  logic          phase;
  logic          in_blank;
  logic [3:0]    cur;
  logic [3:0]    blank;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= 2'd0;
      s0    <= 4'h0;
      s1    <= 4'h0;
      s2    <= 4'h0;
      s3    <= 4'h0;
      bcnt  <= '0;
      phase <= 1'b0;
      frame <= 1'b0;
    end else begin
      // blink timebase is free-running so phase is independent of scan state
      if (bcnt == BLINK_LAST) begin
        bcnt  <= '0;
        phase <= ~phase;
      end else begin
        bcnt <= bcnt + 1'b1;
      end

      frame <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            state <= SCAN;
            cnt   <= '0;
            idx   <= 2'd0;
            s0    <= d0;
            s1    <= d1;
            s2    <= d2;
            s3    <= d3;
            frame <= 1'b1;
          end
        end
        SCAN: begin
          if (!en) begin
            state <= IDLE;
          end else if (cnt == SCAN_LAST) begin
            cnt <= '0;
            idx <= idx + 1'b1;
            // snapshot only at the frame boundary so a counter never tears mid-frame
            if (idx == 2'd3) begin
              s0    <= d0;
              s1    <= d1;
              s2    <= d2;
              s3    <= d3;
              frame <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  generate
    if (BLANK_CYC == 0) begin : g_noblank
      assign in_blank = 1'b0;
    end else begin : g_blank
      localparam logic [CW-1:0] BLANK_V = CW'(BLANK_CYC);
      assign in_blank = (cnt < BLANK_V);
    end
  endgenerate

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    case (idx)
      2'd0:    cur = s0;
      2'd1:    cur = s1;
      2'd2:    cur = s2;
      default: cur = s3;
    endcase
    blank[3] = lz_en && (s3 == 4'h0);
    blank[2] = lz_en && (s3 == 4'h0) && (s2 == 4'h0);
    blank[1] = lz_en && (s3 == 4'h0) && (s2 == 4'h0) && (s1 == 4'h0);
    blank[0] = 1'b0;
    blank    = blank | (phase ? blink_mask : 4'h0);
    an  = 4'hF;
    seg = 7'h7F;
    if (state == SCAN && !in_blank && !blank[idx]) begin
      an  = ~(4'b0001 << idx);
      seg = hex7(cur);
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl
// Directed test-plan steps then random stimulus against a time-based reference model.
module tb_seg_scan_ctrl;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int BD = 64;
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [11:0] DARK = {4'hF, 7'h7F, 1'b0};

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       en = 1'b0;
  logic       lz_en = 1'b0;
  logic [3:0] d0 = 4'h0, d1 = 4'h0, d2 = 4'h0, d3 = 4'h0;
  logic [3:0] blink_mask = 4'h0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame;

  int checks = 0;
  int fails  = 0;

  // model: scan time since entry, snapshot, edges since reset release
  bit         m_scan = 1'b0;
  int         m_t = 0;
  int         m_bc = 0;
  logic [3:0] m_snap [4];

  always #5 clk = ~clk;

  seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_DIV(BD)) dut (
    .clk(clk), .rstn(rstn), .en(en),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .lz_en(lz_en), .blink_mask(blink_mask),
    .an(an), .seg(seg), .frame(frame)
  );

  function automatic logic [11:0] expect_out();
    int         slot, pos;
    bit         fr, blanked, phase;
    logic [3:0] anv;
    if (!m_scan) return DARK;
    slot  = (m_t / SD) % 4;
    pos   = m_t % SD;
    fr    = (m_t % (4 * SD)) == 0;
    phase = ((m_bc / BD) % 2) == 1;
    blanked = 1'b0;
    if (lz_en && slot > 0) begin
      blanked = 1'b1;
      for (int j = slot; j < 4; j++)
        if (m_snap[j] != 4'h0) blanked = 1'b0;
    end
    if (phase && blink_mask[slot]) blanked = 1'b1;
    if (pos < BC || blanked) return {4'hF, 7'h7F, fr};
    anv = 4'hF;
    anv[slot] = 1'b0;
    return {anv, HEX[m_snap[slot]], fr};
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed an/seg/frame=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    m_bc++;
    if (!m_scan) begin
      if (en) begin
        m_scan = 1'b1;
        m_t = 0;
        m_snap = '{d0, d1, d2, d3};
      end
    end else if (!en) begin
      m_scan = 1'b0;
    end else begin
      m_t++;
      if (m_t % (4 * SD) == 0) m_snap = '{d0, d1, d2, d3};
    end
    #1;
    chk(tag, {an, seg, frame}, expect_out());
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic run_to(input string tag, input int phase_t);
    for (int i = 0; i < 4 * SD + 2 && !(m_scan && (m_t % (4 * SD)) == phase_t); i++) tick(tag);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    chk("async_reset", {an, seg, frame}, DARK);
    m_scan = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("in_reset", {an, seg, frame}, DARK);
    end
    m_bc = 0;
    rstn = 1'b1;
  endtask

  initial begin
    m_snap = '{4'h0, 4'h0, 4'h0, 4'h0};
    #2;
    do_reset();

    // idle with en low
    run("idle", 50);

    // 1,2,3,4 scan
    {d3, d2, d1, d0} = 16'h1234;
    en = 1'b1;
    tick("scan_start");
    chk("frame_first", {an, seg, frame}, {4'hF, 7'h7F, 1'b1});
    run("scan", 2);
    chk("slot0_lit", {an, seg, frame}, {4'hE, 7'h19, 1'b0});
    run("scan", 61);

    // d0 change during slot 2 must not tear
    run_to("tear_wait", 17);
    d0 = 4'h8;
    run("no_tear", 16);
    run_to("new_frame", 2);
    chk("new_frame_d0", {an, seg, frame}, {4'hE, 7'h00, 1'b0});

    // leading zero suppression
    lz_en = 1'b1;
    {d3, d2, d1, d0} = 16'h0000;
    run("lz_all0", 64);
    {d3, d2, d1, d0} = 16'h0F00;
    run("lz_0F00", 64);

    // blink digit 0
    lz_en = 1'b0;
    {d3, d2, d1, d0} = 16'h1234;
    blink_mask = 4'b0001;
    run("blink", 200);
    blink_mask = 4'b0000;

    // en drop mid slot 1, re-raise
    run_to("drop_wait", 10);
    en = 1'b0;
    tick("en_drop");
    chk("en_drop_dark", {an, seg, frame}, DARK);
    run("idle2", 5);
    {d3, d2, d1, d0} = 16'hABCD;
    en = 1'b1;
    tick("reenter");
    chk("reenter_frame", {an, seg, frame}, {4'hF, 7'h7F, 1'b1});
    run("reenter_scan", 40);

    // async reset mid slot
    run_to("rst_wait", 12);
    #2;
    do_reset();
    run("post_reset", 40);

    // random stimulus
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(7) == 0) {d3, d2, d1, d0} = 16'($urandom);
      if ($urandom_range(99) == 0) en = ~en;
      if ($urandom_range(49) == 0) lz_en = 1'($urandom);
      if ($urandom_range(49) == 0) blink_mask = 4'($urandom);
      if ($urandom_range(31) == 0) {d3, d2} = 8'h00;
      tick("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
